// File: rtl/unsigned_divider_seq.sv
//------------------------------------------------------------------------------
// Module  : unsigned_divider_seq
// Brief   : Sequential restoring unsigned divider, one quotient bit per clock.
//           Optional macro UDIV_ZERO_FAST_EN: divide-by-zero bypasses RUN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module unsigned_divider_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int             c_CW   = $clog2(N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_div;
    logic [c_CW-1:0] r_cnt;

    logic [N:0]      w_t;
    logic            w_ge;
    logic [N:0]      w_rem_nxt;
    logic [N-1:0]    w_q_nxt;

    // One restoring step: shift the next dividend bit into the partial remainder
    assign w_t       = {r_rem[N-1:0], r_q[N-1]};
    assign w_ge      = (w_t >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? (w_t - {1'b0, r_div}) : w_t;
    assign w_q_nxt   = {r_q[N-2:0], w_ge};

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_div   <= divisor;
                        r_rem   <= '0;
                        r_q     <= dividend;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
`ifdef UDIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            r_state     <= S_DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state     <= S_DONE;
                        quotient    <= w_q_nxt;
                        remainder   <= w_rem_nxt[N-1:0];
                        div_by_zero <= (r_div == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/unsigned_divider_seq.md
# unsigned_divider_seq

Sequential unsigned restoring divider: the inverse operation of the team's parameterised unsigned array multiplier. It accepts an N-bit dividend and divisor through a start/done handshake and produces an N-bit quotient and remainder, one quotient bit per clock. Arithmetic datapaths use it where area matters more than single-cycle latency.

## Interface
- N, default 4: operand width in bits; legal for N >= 2.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a division; accepted only when busy=0.
- dividend  input  N  numerator; sampled on the accepting edge only.
- divisor  input  N  denominator; sampled on the accepting edge only.
- busy  output  1  high while a division is in progress (RUN state).
- done  output  1  one-cycle pulse; quotient/remainder/div_by_zero are valid while it is high.
- quotient  output  N  result quotient; held until the next done.
- remainder  output  N  result remainder; held until the next done.
- div_by_zero  output  1  set with done when the sampled divisor was 0; held until the next done.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter, partial remainder and shift register are all 0.
- IDLE or DONE with start=1: capture the operands; partial remainder R (N+1 bits) = 0; Q = dividend; count = 0; go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- Each RUN cycle performs one restoring step: T = {R[N-1:0], Q[N-1]}. If T >= {1'b0, divisor}, then R = T - divisor and the new Q LSB = 1. Otherwise R = T and the new Q LSB = 0. Q shifts left by one. count increments.
- When count reaches N-1 and the step completes, the block goes to DONE. On that same edge it loads quotient=Q and remainder=R[N-1:0], and sets div_by_zero = (divisor==0).
- DONE: done=1 and busy=0 for exactly one cycle.
- start while busy=1: ignored. No queueing, and the captured operands are not disturbed.
- Divisor 0: the algorithm naturally yields quotient = all ones and remainder = dividend. These are the required results for divide-by-zero.
- rst asserted in any state, including mid-RUN, aborts the operation. No done is produced and every output returns to its reset value on that edge.
- Invariant when div_by_zero=0: quotient*divisor + remainder == dividend, and remainder < divisor.

## Timing
- Start sampled high at the end of cycle c (busy=0): busy=1 in cycles c+1 through c+N; done=1 in cycle c+N+1.
- Latency from the accepting edge to done: N+1 cycles. Throughput: one division per N+1 cycles.
- Back-to-back operation: a start in the DONE cycle is accepted, and busy rises in the following cycle.
- quotient, remainder and div_by_zero change only on the edge that enters DONE, or on reset.
- done and busy are never high in the same cycle.

## Configuration
- UDIV_ZERO_FAST_EN defined: a divisor of 0 on the accepting edge skips RUN and goes directly to DONE. done rises in cycle c+1, with quotient = all ones, remainder = dividend and div_by_zero=1. busy stays 0 throughout.
- UDIV_ZERO_FAST_EN undefined: a divisor of 0 runs the full N steps. The results are identical to the defined case; only the latency differs (N+1 cycles).
- Non-zero divisors behave identically in both builds.

## Test plan
- N=4, dividend=13, divisor=3 -> busy for 4 cycles, then done with quotient=4, remainder=1, div_by_zero=0.
- N=4: 15/1 -> quotient=15, remainder=0. 3/5 -> quotient=0, remainder=3. 0/7 -> quotient=0, remainder=0.
- N=4, dividend=7, divisor=0 -> quotient=15, remainder=7, div_by_zero=1. done arrives in cycle c+1 with UDIV_ZERO_FAST_EN defined, and in cycle c+5 without it.
- Start 9/2 accepted; pulse start with 15/4 during RUN -> ignored, so done shows quotient=4, remainder=1. Then start 15/4 in the DONE cycle -> accepted, and done 5 cycles later shows quotient=3, remainder=3.
- Start 12/5, then assert rst in the second RUN cycle -> all outputs 0 on the next edge and no done. A fresh 12/5 afterwards -> quotient=2, remainder=2.
- Randomised sweep over all 256 operand pairs for N=4 -> every done matches a reference model, with divide-by-zero checked against the rule above.
